decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode pipeline stage between fetch and execute in the RV32I core. Accepts one instruction per cycle from fetch over a valid/ready handshake, drives the register bank read addresses, captures operands, immediate and control fields into the ID/EX register, and inserts a one-cycle bubble on load-use hazards.

## Interface
- XLEN, 32, data/PC width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch holds a valid instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- A1, A2  out  5  register bank read addresses (instr[19:15], instr[24:20])
- RD1, RD2  in  XLEN  register bank read data
- wb_we, wb_rd, wb_data  in  1/5/XLEN  write-back write enable, address and data (same signals as bank WE3/A3/WD3)
- flush  in  1  squash ID/EX contents
- ex_ready  in  1  execute accepts ID/EX this cycle
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  captured PC, operands, sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5  register indices
- ex_op  out  4  op class (riscv_pkg::op_class_e)
- ex_funct3  out  3; ex_funct7b5  out  1
- ex_mem_read, ex_reg_write, ex_illegal  out  1

## Operation
- Decoded opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; anything else → op ILLEGAL, ex_illegal=1, reg_write=0, mem_read=0.
- Immediate: I for JALR/LOAD/OP-IMM, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL, 0 for OP/ILLEGAL; always sign-extended from instr[31].
- uses_rs1: all legal ops except LUI/AUIPC/JAL; uses_rs2: BRANCH, STORE, OP.
- reg_write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; ex_rd forced 0 when reg_write=0.
- load_use = ex_valid & ex_mem_read & ex_rd≠0 & if_valid & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- if_ready = !rst & !load_use & (!ex_valid | ex_ready) | flush.
- Register update priority: rst > flush > accept (if_valid & if_ready) > bubble (ex_ready & no accept → ex_valid=0) > hold.
- flush: ex_valid←0; current fetch instruction consumed and discarded (if_ready=1).
- Load-use: bubble inserted once ex_ready; instruction held in fetch, accepted the cycle after the load leaves.
- Index 0 operand value always 0.

## Timing
- Reset: ex_valid=0, all ex_* fields 0, ex_op=ILLEGAL encoding 0 not asserted (ex_illegal=0); if_ready=0 while rst high.
- Latency: 1 cycle fetch accept → ex_valid.
- A1/A2 combinational from if_instr; RD1/RD2 sampled at the accept edge.
- Held ID/EX outputs stable while ex_valid & !ex_ready.
- Throughput 1 instr/cycle absent hazards/backpressure.

## Configuration
- DECODE_WB_BYPASS_EN defined: operand = wb_data when wb_we & wb_rd≠0 & wb_rd==rs index, else RDx (write-back same cycle as decode visible).
- Undefined: operand = RDx directly; write-back/decode same-cycle hazard handled by the hazard unit (one extra stall cycle upstream).

## Structure
- riscv_pkg: op_class_e enum (ILLEGAL=0, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP), opcode localparams, XLEN.
- Sub-module imm_gen: combinational instr → imm, format selected by opcode.

## Test plan
- Reset then ADDI x5,x1,-1 (0xFFF08293), RD1=10 → next cycle ex_valid=1, ex_rd=5, ex_imm=0xFFFFFFFF, ex_rs1_val=10, ex_reg_write=1.
- LW x3,0(x2) then ADD x4,x3,x1 back-to-back → if_ready=0 one cycle, ex_valid=0 bubble, ADD accepted next cycle.
- ex_ready=0 for 3 cycles with if_valid=1 → if_ready=0, ID/EX fields unchanged; ex_ready=1 → next instruction loaded.
- flush with ex_valid=1 and if_valid=1 → next cycle ex_valid=0, incoming instruction dropped.
- Opcode 0x0000007F → ex_illegal=1, ex_reg_write=0, ex_rd=0.
- With DECODE_WB_BYPASS_EN: wb_we=1, wb_rd=1, wb_data=0xDEAD, RD1=0 decoding rs1=x1 → ex_rs1_val=0xDEAD; wb_rd=0 → no bypass.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I shared definitions for the decode stage: data width, opcode map,
// op-class encoding and the per-opcode control decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ILLEGAL = 4'd0,
    LUI     = 4'd1,
    AUIPC   = 4'd2,
    JAL     = 4'd3,
    JALR    = 4'd4,
    BRANCH  = 4'd5,
    LOAD    = 4'd6,
    STORE   = 4'd7,
    OPIMM   = 4'd8,
    OP      = 4'd9
  } op_class_e;

  typedef struct packed {
    op_class_e op;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      reg_write;
    logic      mem_read;
    logic      illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c = '{op: ILLEGAL, uses_rs1: 1'b0, uses_rs2: 1'b0,
          reg_write: 1'b0, mem_read: 1'b0, illegal: 1'b0};
    case (opcode)
      OPC_LUI:    begin c.op = LUI;    c.reg_write = 1'b1; end
      OPC_AUIPC:  begin c.op = AUIPC;  c.reg_write = 1'b1; end
      OPC_JAL:    begin c.op = JAL;    c.reg_write = 1'b1; end
      OPC_JALR:   begin c.op = JALR;   c.reg_write = 1'b1; c.uses_rs1 = 1'b1; end
      OPC_BRANCH: begin c.op = BRANCH; c.uses_rs1 = 1'b1;  c.uses_rs2 = 1'b1; end
      OPC_LOAD: begin
        c.op        = LOAD;
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.uses_rs1  = 1'b1;
      end
      OPC_STORE:  begin c.op = STORE;  c.uses_rs1 = 1'b1;  c.uses_rs2 = 1'b1; end
      OPC_OPIMM:  begin c.op = OPIMM;  c.reg_write = 1'b1; c.uses_rs1 = 1'b1; end
      OPC_OP: begin
        c.op        = OP;
        c.reg_write = 1'b1;
        c.uses_rs1  = 1'b1;
        c.uses_rs2  = 1'b1;
      end
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J format from
// the opcode and sign-extends from instr[31]; OP and unknown opcodes give 0.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0]            instr,
  output logic signed [XLEN-1:0] imm
);

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = imm_i;
      OPC_STORE:                     imm = imm_s;
      OPC_BRANCH:                    imm = imm_b;
      OPC_LUI, OPC_AUIPC:            imm = imm_u;
      OPC_JAL:                       imm = imm_j;
      default:                       imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage feeding the ID/EX register, with load-use bubble.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle write-back data into operands.
module decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output op_class_e       ex_op,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_mem_read,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  // Stage p0: combinational decode of the instruction offered by fetch
  logic [4:0]             rs1_p0, rs2_p0, rd_p0;
  ctrl_t                  ctrl_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [XLEN-1:0]        rs1_val_p0, rs2_val_p0;

  assign rs1_p0  = if_instr[19:15];
  assign rs2_p0  = if_instr[24:20];
  assign ctrl_p0 = decode_ctrl(if_instr[6:0]);
  assign rd_p0   = ctrl_p0.reg_write ? if_instr[11:7] : 5'd0;
  assign A1      = rs1_p0;
  assign A2      = rs2_p0;

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (imm_p0)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val_p0 = (rs1_p0 == 5'd0) ? '0 :
                      (wb_we && wb_rd == rs1_p0) ? wb_data : RD1;
  assign rs2_val_p0 = (rs2_p0 == 5'd0) ? '0 :
                      (wb_we && wb_rd == rs2_p0) ? wb_data : RD2;
`else
  // Without the bypass, the hazard unit upstream stalls a cycle on write-back conflicts.
  logic unused_wb;
  assign unused_wb  = ^{wb_we, wb_rd, wb_data};
  assign rs1_val_p0 = (rs1_p0 == 5'd0) ? '0 : RD1;
  assign rs2_val_p0 = (rs2_p0 == 5'd0) ? '0 : RD2;
`endif

  // ID/EX register state
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1, rs1_val_p1, rs2_val_p1, imm_p1;
  logic [4:0]      rs1_p1, rs2_p1, rd_p1;
  op_class_e       op_p1;
  logic [2:0]      funct3_p1;
  logic            funct7b5_p1, mem_read_p1, reg_write_p1, illegal_p1;

  logic load_use, accept;

  // A load in ID/EX whose destination feeds the incoming instruction forces a bubble.
  assign load_use = vld_p1 && mem_read_p1 && (rd_p1 != 5'd0) && if_valid &&
                    ((ctrl_p0.uses_rs1 && rs1_p0 == rd_p1) ||
                     (ctrl_p0.uses_rs2 && rs2_p0 == rd_p1));

  assign if_ready = (!rst && !load_use && (!vld_p1 || ex_ready)) || flush;
  assign accept   = if_valid && if_ready;

  // Stage p1: ID/EX register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_val_p1   <= '0;
      rs2_val_p1   <= '0;
      imm_p1       <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      op_p1        <= ILLEGAL;
      funct3_p1    <= '0;
      funct7b5_p1  <= 1'b0;
      mem_read_p1  <= 1'b0;
      reg_write_p1 <= 1'b0;
      illegal_p1   <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1       <= 1'b1;
      pc_p1        <= if_pc;
      rs1_val_p1   <= rs1_val_p0;
      rs2_val_p1   <= rs2_val_p0;
      imm_p1       <= imm_p0;
      rs1_p1       <= rs1_p0;
      rs2_p1       <= rs2_p0;
      rd_p1        <= rd_p0;
      op_p1        <= ctrl_p0.op;
      funct3_p1    <= if_instr[14:12];
      funct7b5_p1  <= if_instr[30];
      mem_read_p1  <= ctrl_p0.mem_read;
      reg_write_p1 <= ctrl_p0.reg_write;
      illegal_p1   <= ctrl_p0.illegal;
    end else if (ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_pc        = pc_p1;
  assign ex_rs1_val   = rs1_val_p1;
  assign ex_rs2_val   = rs2_val_p1;
  assign ex_imm       = imm_p1;
  assign ex_rs1       = rs1_p1;
  assign ex_rs2       = rs2_p1;
  assign ex_rd        = rd_p1;
  assign ex_op        = op_p1;
  assign ex_funct3    = funct3_p1;
  assign ex_funct7b5  = funct7b5_p1;
  assign ex_mem_read  = mem_read_p1;
  assign ex_reg_write = reg_write_p1;
  assign ex_illegal   = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, hand-written hazard,
// backpressure, flush and bypass sequences, then randomized traffic against a reference model.
module tb_decode_stage;
  import riscv_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, flush, ex_ready, wb_we;
  logic [31:0] if_instr, if_pc, RD1, RD2, wb_data;
  logic [4:0]  A1, A2, wb_rd, ex_rs1, ex_rs2, ex_rd;
  logic        ex_valid, ex_funct7b5, ex_mem_read, ex_reg_write, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  op_class_e   ex_op;
  logic [2:0]  ex_funct3;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op(ex_op),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  int ntests = 0;
  int nfail  = 0;
  logic rdy_seen;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7, mr, rw, ill, u1, u2;
  } slot_t;

  slot_t m;

  typedef struct {
    logic [31:0] instr, rd1, imm, rs1v;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] idx, input logic [31:0] d,
                                       input logic we, input logic [4:0] wrd,
                                       input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && we && wrd == idx) return wd;
    return d;
  endfunction

  // Reference decode written from the instruction-format definitions.
  function automatic slot_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] d1, input logic [31:0] d2,
                                       input logic we, input logic [4:0] wrd,
                                       input logic [31:0] wd);
    slot_t s;
    logic signed [31:0] is;
    logic [31:0] sx, iimm, simm_hi;
    s = '0;
    is = $signed(i);
    sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
    iimm = is >>> 20;
    simm_hi = is >>> 25;
    s.vld = 1'b1; s.pc = pc; s.rs1 = i[19:15]; s.rs2 = i[24:20];
    s.f3 = i[14:12]; s.f7 = i[30];
    case (i[6:0])
      7'h37: begin s.op = 4'd1; s.imm = i & 32'hFFFF_F000; s.rw = 1; end
      7'h17: begin s.op = 4'd2; s.imm = i & 32'hFFFF_F000; s.rw = 1; end
      7'h6F: begin
        s.op = 4'd3; s.rw = 1;
        s.imm = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      7'h67: begin s.op = 4'd4; s.imm = iimm; s.rw = 1; s.u1 = 1; end
      7'h63: begin
        s.op = 4'd5; s.u1 = 1; s.u2 = 1;
        s.imm = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      7'h03: begin s.op = 4'd6; s.imm = iimm; s.rw = 1; s.mr = 1; s.u1 = 1; end
      7'h23: begin s.op = 4'd7; s.imm = (simm_hi << 5) | 32'(i[11:7]); s.u1 = 1; s.u2 = 1; end
      7'h13: begin s.op = 4'd8; s.imm = iimm; s.rw = 1; s.u1 = 1; end
      7'h33: begin s.op = 4'd9; s.rw = 1; s.u1 = 1; s.u2 = 1; end
      default: s.ill = 1;
    endcase
    s.rd   = s.rw ? i[11:7] : 5'd0;
    s.rs1v = opnd(i[19:15], d1, we, wrd, wd);
    s.rs2v = opnd(i[24:20], d2, we, wrd, wd);
    return s;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance model, check ID/EX after the edge.
  task automatic cyc();
    slot_t cur;
    logic lu, rdy;
    #3;
    cur = ref_decode(if_instr, if_pc, RD1, RD2, wb_we, wb_rd, wb_data);
    lu  = m.vld && m.mr && (m.rd != 5'd0) && if_valid &&
          ((cur.u1 && cur.rs1 == m.rd) || (cur.u2 && cur.rs2 == m.rd));
    rdy = (!rst && !lu && (!m.vld || ex_ready)) || flush;
    rdy_seen = if_ready;
    chk("if_ready", 32'(if_ready), 32'(rdy));
    chk("A1", 32'(A1), 32'(if_instr[19:15]));
    chk("A2", 32'(A2), 32'(if_instr[24:20]));
    if (rst)                     m = '0;
    else if (flush)              m.vld = 1'b0;
    else if (if_valid && rdy)    m = cur;
    else if (ex_ready)           m.vld = 1'b0;
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m.vld));
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rs1_val", ex_rs1_val, m.rs1v);
    chk("ex_rs2_val", ex_rs2_val, m.rs2v);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
    chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
    chk("ex_rd", 32'(ex_rd), 32'(m.rd));
    chk("ex_op", 32'(ex_op), 32'(m.op));
    chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
    chk("ex_funct7b5", 32'(ex_funct7b5), 32'(m.f7));
    chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
    chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;
      3: r[6:0] = 7'h67;  4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;
      6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;  8: r[6:0] = 7'h33;
      9: r[6:0] = 7'h03;
      default: r[6:0] = 7'h7F;
    endcase
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    r[11:7]  = 5'($urandom_range(0, 3));
    return r;
  endfunction

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'hFFF08293, 32'd10,   32'hFFFFFFFF, 32'd10,   4'd8, 5'd5,  1, 0, 0};
    vecs[1]  = '{32'h0000007F, 32'd7,    32'h0,        32'd0,    4'd0, 5'd0,  0, 0, 1};
    vecs[2]  = '{32'h123453B7, 32'h11,   32'h12345000, 32'h11,   4'd1, 5'd7,  1, 0, 0};
    vecs[3]  = '{32'hFE612E23, 32'h22,   32'hFFFFFFFC, 32'h22,   4'd7, 5'd0,  0, 0, 0};
    vecs[4]  = '{32'hFE208CE3, 32'h33,   32'hFFFFFFF8, 32'h33,   4'd5, 5'd0,  0, 0, 0};
    vecs[5]  = '{32'h001000EF, 32'h44,   32'h00000800, 32'h0,    4'd3, 5'd1,  1, 0, 0};
    vecs[6]  = '{32'h00012183, 32'h66,   32'h0,        32'h66,   4'd6, 5'd3,  1, 1, 0};
    vecs[7]  = '{32'h00118233, 32'h77,   32'h0,        32'h77,   4'd9, 5'd4,  1, 0, 0};
    vecs[8]  = '{32'hFFFFF517, 32'h88,   32'hFFFFF000, 32'h88,   4'd2, 5'd10, 1, 0, 0};
    vecs[9]  = '{32'h00008067, 32'h99,   32'h0,        32'h99,   4'd4, 5'd0,  1, 0, 0};
    vecs[10] = '{32'h40315093, 32'hAA,   32'h00000403, 32'hAA,   4'd8, 5'd1,  1, 0, 0};
    vecs[11] = '{32'h00F0050F, 32'hBB,   32'h0,        32'h0,    4'd0, 5'd0,  0, 0, 1};

    m = '0;
    rst = 1; if_valid = 0; flush = 0; ex_ready = 1; wb_we = 0; wb_rd = 0; wb_data = 0;
    if_instr = 0; if_pc = 0; RD1 = 0; RD2 = 0;
    @(posedge clk); #1;
    cyc();
    cyc();
    chk("rst_if_ready", 32'(rdy_seen), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_illegal", 32'(ex_illegal), 32'd0);
    rst = 0;

    // Decode table
    for (int k = 0; k < 12; k++) begin
      if_valid = 1; if_instr = vecs[k].instr; if_pc = 32'h100 + 32'(k * 4);
      RD1 = vecs[k].rd1; RD2 = 32'h55;
      cyc();
      chk("tbl_valid", 32'(ex_valid), 32'd1);
      chk("tbl_op", 32'(ex_op), 32'(vecs[k].op));
      chk("tbl_imm", ex_imm, vecs[k].imm);
      chk("tbl_rd", 32'(ex_rd), 32'(vecs[k].rd));
      chk("tbl_reg_write", 32'(ex_reg_write), 32'(vecs[k].rw));
      chk("tbl_mem_read", 32'(ex_mem_read), 32'(vecs[k].mr));
      chk("tbl_illegal", 32'(ex_illegal), 32'(vecs[k].ill));
      chk("tbl_rs1_val", ex_rs1_val, vecs[k].rs1v);
      if_valid = 0;
      cyc();
    end

    // Load-use: LW x3 then ADD x4,x3,x1
    if_valid = 1; if_instr = 32'h00012183; if_pc = 32'h300; RD1 = 32'h1000;
    cyc();
    chk("lu_lw_valid", 32'(ex_valid), 32'd1);
    if_instr = 32'h00118233; if_pc = 32'h304; RD1 = 32'h5; RD2 = 32'h6;
    cyc();
    chk("lu_stall_ready", 32'(rdy_seen), 32'd0);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    cyc();
    chk("lu_add_ready", 32'(rdy_seen), 32'd1);
    chk("lu_add_pc", ex_pc, 32'h304);
    chk("lu_add_rd", 32'(ex_rd), 32'd4);

    // Backpressure: ID/EX held for three cycles
    if_instr = 32'hFFF08293; if_pc = 32'h400; RD1 = 32'd10;
    cyc();
    ex_ready = 0; if_instr = 32'h00118233; if_pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_ready", 32'(rdy_seen), 32'd0);
      chk("bp_pc_hold", ex_pc, 32'h400);
      chk("bp_imm_hold", ex_imm, 32'hFFFFFFFF);
    end
    ex_ready = 1;
    cyc();
    chk("bp_release_ready", 32'(rdy_seen), 32'd1);
    chk("bp_next_pc", ex_pc, 32'h404);

    // Flush with valid ID/EX and incoming instruction
    flush = 1; if_instr = 32'h123453B7; if_pc = 32'h408;
    cyc();
    chk("fl_ready", 32'(rdy_seen), 32'd1);
    chk("fl_valid", 32'(ex_valid), 32'd0);
    flush = 0; if_valid = 0;
    cyc();
    chk("fl_dropped", 32'(ex_valid), 32'd0);

    // Same-cycle write-back to rs1
    if_valid = 1; if_instr = 32'hFFF08293; if_pc = 32'h500; RD1 = 0;
    wb_we = 1; wb_rd = 5'd1; wb_data = 32'hDEAD;
    cyc();
    chk("wb_rs1_val", ex_rs1_val, BYPASS ? 32'hDEAD : 32'h0);
    wb_rd = 5'd0; if_pc = 32'h504;
    cyc();
    chk("wb_rd0_val", ex_rs1_val, 32'h0);
    wb_we = 0;

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      if_instr = rand_instr();
      if_pc    = $urandom & 32'hFFFF_FFFC;
      RD1      = $urandom;
      RD2      = $urandom;
      wb_we    = ($urandom_range(0, 1) != 0);
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
